// File: rtl/m_seg_pkg.sv
// m_seg_pkg: shared 7-segment definitions for the scan driver and the digit decoder.
//   SEG_0..SEG_F : active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F
//   SEG_OFF      : all eight segments (dp included) dark
//   seg7()       : pure nibble -> 7-bit active-low pattern lookup
package m_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b0100111;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  function automatic logic [6:0] seg7(input logic [3:0] nibble);
    logic [6:0] pat;
    pat = '1;
    case (nibble)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      4'hF: pat = SEG_F;
      default: pat = '1;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/m_seven_segment.sv
// m_seven_segment: combinational single-digit decoder.
//   idat [3:0] : hex nibble
//   idp        : decimal point request (1 = lit)
//   oseg [7:0] : active-low {dp,g,f,e,d,c,b,a}
module m_seven_segment
  import m_seg_pkg::*;
(
  input  logic [3:0] idat,
  input  logic       idp,
  output logic [7:0] oseg
);

  assign oseg = {~idp, seg7(idat)};

endmodule

// File: rtl/m_seven_segment_scan.sv
// m_seven_segment_scan: time-multiplexed driver for an N-digit common-anode
// 7-segment display. Inputs are snapshotted once per frame (tear-free); each
// digit slot starts with BLANK_CYCLES of dead time to suppress ghosting.
//   clk, rst       : clock, synchronous active-high reset
//   idat [4N-1:0]  : packed nibbles, digit 0 rightmost
//   idp  [N-1:0]   : decimal point request per digit
//   ien  [N-1:0]   : digit enable
//   odat [7:0]     : registered active-low segments {dp,g,f,e,d,c,b,a}
//   odigit [N-1:0] : registered active-low digit select, at most one low
//   oframe         : one-cycle pulse the cycle after a snapshot
// Build option: define LEADING_ZERO_BLANK_EN to dark leading zero digits.
module m_seven_segment_scan
  import m_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] idat,
  input  logic [N_DIGITS-1:0]   idp,
  input  logic [N_DIGITS-1:0]   ien,
  output logic [7:0]            odat,
  output logic [N_DIGITS-1:0]   odigit,
  output logic                  oframe
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   sh_dat_q;
  logic [N_DIGITS-1:0]     sh_dp_q, sh_en_q;
  logic [7:0]              odat_q, odat_d;
  logic [N_DIGITS-1:0]     odigit_q, odigit_d;
  logic                    oframe_q;

  logic                    cnt_last, idx_last, snap, in_blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_en, cur_lz;
  logic [N_DIGITS-1:0]     lz_mask;
  logic [7:0]              dec_seg;

  assign cnt_last = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign idx_last = (idx_q == IDX_W'(N_DIGITS - 1));
  assign snap     = (cnt_q == '0) && (idx_q == '0);

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_q < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_last) begin
      cnt_d = '0;
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end
  end

  // Select the current digit's shadow fields.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = sh_dat_q[4*i +: 4];
        cur_dp  = sh_dp_q[i];
        cur_en  = sh_en_q[i];
        cur_lz  = lz_mask[i];
      end
    end
  end

  // Leading-zero mask: walk from the top digit down while digits are zero with
  // no dp; digit 0 is excluded so a zero value still shows "0".
  always_comb begin
    lz_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin : lzb
      logic leading;
      leading = 1'b1;
      for (int unsigned j = 1; j < N_DIGITS; j++) begin
        if (leading && (sh_dat_q[4*(N_DIGITS-j) +: 4] == 4'h0) && !sh_dp_q[N_DIGITS-j])
          lz_mask[N_DIGITS-j] = 1'b1;
        else
          leading = 1'b0;
      end
    end
`endif
  end

  m_seven_segment u_dec (
    .idat (cur_nib),
    .idp  (cur_dp),
    .oseg (dec_seg)
  );

  always_comb begin
    odat_d   = SEG_OFF;
    odigit_d = '1;
    if (!in_blank && cur_en && !cur_lz) begin
      odat_d = dec_seg;
      for (int unsigned i = 0; i < N_DIGITS; i++)
        odigit_d[i] = (idx_q != IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_dat_q <= '0;
      sh_dp_q  <= '0;
      sh_en_q  <= '0;
      odat_q   <= SEG_OFF;
      odigit_q <= '1;
      oframe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      if (snap) begin
        sh_dat_q <= idat;
        sh_dp_q  <= idp;
        sh_en_q  <= ien;
      end
      odat_q   <= odat_d;
      odigit_q <= odigit_d;
      oframe_q <= snap;
    end
  end

  assign odat   = odat_q;
  assign odigit = odigit_q;
  assign oframe = oframe_q;

endmodule

// File: tb/tb_m_seven_segment_scan.sv
module tb_m_seven_segment_scan;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BL = 2;
  localparam int FR = N * SD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*N-1:0] idat = '0;
  logic [N-1:0]  idp = '0;
  logic [N-1:0]  ien = '0;
  logic [7:0]    odat;
  logic [N-1:0]  odigit;
  logic          oframe;

  m_seven_segment_scan #(
    .N_DIGITS     (N),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .idat   (idat),
    .idp    (idp),
    .ien    (ien),
    .odat   (odat),
    .odigit (odigit),
    .oframe (oframe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   dat;
    logic [N-1:0] dig;
    logic         fr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int pushed = 0;
  int popped = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: cycle count since reset release, frame snapshot.
  int         t = 0;
  logic [4*N-1:0] s_dat = '0;
  logic [N-1:0]   s_dp = '0;
  logic [N-1:0]   s_en = '0;

  function automatic logic suppressed(int d);
`ifdef LEADING_ZERO_BLANK_EN
    int top = 0;
    for (int k = 0; k < N; k++)
      if (((s_dat >> (4*k)) & 16'hF) != 0 || s_dp[k]) top = k;
    return (d != 0) && (d > top);
`else
    return (d < 0);
`endif
  endfunction

  function automatic exp_t expected(int tt);
    exp_t e;
    int pos = tt % SD;
    int d = (tt / SD) % N;
    logic [3:0] nib;
    e.dat = 8'hFF;
    e.dig = '1;
    e.fr  = (tt % FR == 0);
    nib = 4'((s_dat >> (4*d)) & 16'hF);
    if (pos >= BL && s_en[d] && !suppressed(d)) begin
      e.dat = {~s_dp[d], seg_tab[nib]};
      e.dig = ~(N'(1) << d);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      e.dat = 8'hFF;
      e.dig = '1;
      e.fr  = 1'b0;
      t = 0;
    end else begin
      if (t % FR == 0) begin
        s_dat = idat;
        s_dp  = idp;
        s_en  = ien;
      end
      e = expected(t);
      t++;
    end
    q.push_back(e);
    pushed++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      popped++;
      checks++;
      if (odat === e.dat && odigit === e.dig && oframe === e.fr)
        passed++;
      else
        $display("FAIL scan @%0t: odat=%h odigit=%b oframe=%b, expected odat=%h odigit=%b oframe=%b",
                 $time, odat, odigit, oframe, e.dat, e.dig, e.fr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    idat = 16'h12AF;
    idp  = 4'b0100;
    ien  = 4'hF;
    rst  = 1'b1;
    cyc(3);
    rst = 1'b0;

    // Tear-free: change data mid-frame during slot 1.
    cyc(FR + 12);
    idat = 16'h0000;
    cyc(2 * FR - 12);

    // Enable mask.
    idat = 16'h12AF;
    ien  = 4'b0101;
    cyc(2 * FR);

    // Reset while digit 2 is lit.
    ien = 4'hF;
    for (int k = 0; k < 2 * FR && (t % FR) != 2 * SD + 4; k++) cyc(1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(FR);

    // Leading-zero patterns.
    idat = 16'h0030;
    idp  = 4'b0000;
    cyc(2 * FR);
    idat = 16'h0000;
    cyc(2 * FR);

    // Randomized phase.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        idat = 16'($urandom);
        if ($urandom_range(0, 1) == 1) idat = idat & (16'hFFFF >> (4 * $urandom_range(1, 3)));
        idp  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        ien  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      end
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      cyc(1);
    end

    @(negedge clk);
    #1;
    checks++;
    if (popped == pushed && popped > 0)
      passed++;
    else
      $display("FAIL drain: popped=%0d, expected pushed=%0d", popped, pushed);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
